// File: rtl/fp24_mul_if.sv
// Operand/result handshake bundle for the fp24 multiplier.
// Signals keep their datasheet names so waveforms read directly against the format description.
interface fp24_mul_if;
  logic [23:0] a;
  logic [23:0] b;
  logic        valid_in;
  logic        ready_in;
  logic [23:0] product;
  logic        valid_out;
  logic        ready_out;

  modport master (
    output a, b, valid_in, ready_out,
    input  ready_in, product, valid_out
  );

  modport slave (
    input  a, b, valid_in, ready_out,
    output ready_in, product, valid_out
  );
endinterface

// File: rtl/fp24_mul.sv
// Two-stage fp24 multiplier (1 sign, 7-bit exponent bias 63, 16-bit fraction) with valid/ready flow control.
// The result is truncated and clamped to zero or to the largest finite value; both stages stall together.
module fp24_mul (
  input  logic      clk,
  input  logic      rst,
  fp24_mul_if.slave bus
);

  logic adv;

  logic               sign_p1_d;
  logic               zero_p1_d;
  logic signed [8:0]  exp_p1_d;
  logic [33:0]        mant_p1_d;
  logic               vld_p1_d;

  logic               sign_p1_q;
  logic               zero_p1_q;
  logic signed [8:0]  exp_p1_q;
  logic [33:0]        mant_p1_q;
  logic               vld_p1_q;

  logic [23:0]        res_p2_d;
  logic [23:0]        res_p2_q;
  logic               vld_p2_q;

  // Leading one of the 34-bit product sits at bit 33 or bit 32; fraction is truncated.
  function automatic logic [15:0] norm_mant(input logic [33:0] p);
    return p[33] ? p[32:17] : p[31:16];
  endfunction

  function automatic logic signed [8:0] norm_exp(input logic signed [8:0] e,
                                                 input logic [33:0]      p);
    return p[33] ? (e + 9'sd1) : e;
  endfunction

  function automatic logic [23:0] sat_pack(input logic              sgn,
                                           input logic              zero,
                                           input logic signed [8:0] e,
                                           input logic [15:0]       m);
    if (zero || (e <= 9'sd0)) begin
      return {sgn, 7'd0, 16'd0};
    end
    if (e >= 9'sd128) begin
      return {sgn, 7'd127, 16'hFFFF};
    end
    return {sgn, e[6:0], m};
  endfunction

  assign adv          = !vld_p2_q || bus.ready_out;
  assign bus.ready_in = adv;

  // ---- stage 1: sign, biased exponent sum, raw mantissa product ----
  always_comb begin
    sign_p1_d = bus.a[23] ^ bus.b[23];
    zero_p1_d = (bus.a[22:16] == 7'd0) || (bus.b[22:16] == 7'd0);
    exp_p1_d  = $signed({2'b00, bus.a[22:16]}) + $signed({2'b00, bus.b[22:16]}) - 9'sd63;
    mant_p1_d = {17'd0, 1'b1, bus.a[15:0]} * {17'd0, 1'b1, bus.b[15:0]};
    vld_p1_d  = bus.valid_in && adv;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1_q  <= 1'b0;
      sign_p1_q <= 1'b0;
      zero_p1_q <= 1'b0;
      exp_p1_q  <= 9'sd0;
      mant_p1_q <= 34'd0;
    end else if (adv) begin
      vld_p1_q  <= vld_p1_d;
      sign_p1_q <= sign_p1_d;
      zero_p1_q <= zero_p1_d;
      exp_p1_q  <= exp_p1_d;
      mant_p1_q <= mant_p1_d;
    end
  end

  // ---- stage 2: normalise, clamp, output register ----
  always_comb begin
    res_p2_d = sat_pack(sign_p1_q, zero_p1_q,
                        norm_exp(exp_p1_q, mant_p1_q), norm_mant(mant_p1_q));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p2_q <= 1'b0;
      res_p2_q <= 24'h000000;
    end else if (adv) begin
      vld_p2_q <= vld_p1_q;
      res_p2_q <= res_p2_d;
    end
  end

  assign bus.valid_out = vld_p2_q;
  assign bus.product   = res_p2_q;

endmodule

// File: tb/tb_fp24_mul.sv
// Directed and randomised checks of fp24_mul: arithmetic corner cases, streaming, back-pressure, reset.
module tb_fp24_mul;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  fp24_mul_if bus();

  fp24_mul dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] ref_mul(input logic [23:0] x, input logic [23:0] y);
    longint unsigned ma, mb, p;
    int              e;
    logic [15:0]     m;
    logic            s;
    s = x[23] ^ y[23];
    if ((x[22:16] == 7'd0) || (y[22:16] == 7'd0)) return {s, 23'd0};
    ma = {47'd0, 1'b1, x[15:0]};
    mb = {47'd0, 1'b1, y[15:0]};
    p  = ma * mb;
    e  = int'(x[22:16]) + int'(y[22:16]) - 63;
    if (p >= 64'h2_0000_0000) begin
      m = 16'(p >> 17);
      e = e + 1;
    end else begin
      m = 16'(p >> 16);
    end
    if (e <= 0)   return {s, 23'd0};
    if (e >= 128) return {s, 7'h7F, 16'hFFFF};
    return {s, 7'(e), m};
  endfunction

  function automatic logic [23:0] rand_fp();
    return 24'($urandom());
  endfunction

  // Presents one operand pair and reports the product and the number of edges until valid_out.
  task automatic run_one(input logic [23:0] av, input logic [23:0] bv,
                         output logic [23:0] prod, output int lat);
    bus.a = av;
    bus.b = bv;
    bus.valid_in  = 1'b1;
    bus.ready_out = 1'b1;
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    lat = 1;
    while (!bus.valid_out && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    prod = bus.product;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (bus.valid_out !== 1'b0) begin
      n_err++; $display("FAIL reset valid_out: got %b expected 0", bus.valid_out);
    end
    n_vec++;
    if (bus.product !== 24'h000000) begin
      n_err++; $display("FAIL reset product: got %h expected 000000", bus.product);
    end
    n_vec++;
    if (bus.ready_in !== 1'b1) begin
      n_err++; $display("FAIL reset ready_in: got %b expected 1", bus.ready_in);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_vec++;
    if (bus.ready_in !== 1'b1 || bus.valid_out !== 1'b0) begin
      n_err++; $display("FAIL post-reset idle: got ready_in=%b valid_out=%b expected 1/0",
                        bus.ready_in, bus.valid_out);
    end
  endtask

  task automatic test_directed();
    logic [23:0] va [8];
    logic [23:0] vb [8];
    logic [23:0] ex [8];
    logic [23:0] prod;
    int          lat;
    va[0] = 24'h3F8000; vb[0] = 24'h3F8000; ex[0] = 24'h402000;
    va[1] = 24'h3F0000; vb[1] = 24'h3F0000; ex[1] = 24'h3F0000;
    va[2] = 24'hC08000; vb[2] = 24'h400000; ex[2] = 24'hC18000;
    va[3] = 24'h3FFFFF; vb[3] = 24'h3FFFFF; ex[3] = 24'h40FFFE;
    va[4] = 24'h000000; vb[4] = 24'h3F0000; ex[4] = 24'h000000;
    va[5] = 24'h010000; vb[5] = 24'h010000; ex[5] = 24'h000000;
    va[6] = 24'h7F0000; vb[6] = 24'h7F0000; ex[6] = 24'h7FFFFF;
    va[7] = 24'h800000; vb[7] = 24'h3F0000; ex[7] = 24'h800000;
    for (int i = 0; i < 8; i++) begin
      run_one(va[i], vb[i], prod, lat);
      n_vec++;
      if (lat !== 2) begin
        n_err++; $display("FAIL directed[%0d] latency: got %0d expected 2", i, lat);
      end
      n_vec++;
      if (prod !== ex[i]) begin
        n_err++; $display("FAIL directed[%0d] %h*%h product: got %h expected %h",
                          i, va[i], vb[i], prod, ex[i]);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [23:0] va [8];
    logic [23:0] vb [8];
    logic [23:0] ex [8];
    logic        exp_v;
    for (int i = 0; i < 8; i++) begin
      va[i] = rand_fp();
      vb[i] = rand_fp();
      ex[i] = ref_mul(va[i], vb[i]);
    end
    bus.ready_out = 1'b1;
    bus.a = va[0];
    bus.b = vb[0];
    bus.valid_in = 1'b1;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      exp_v = (c >= 2) && (c <= 9);
      n_vec++;
      if (bus.valid_out !== exp_v) begin
        n_err++; $display("FAIL b2b valid_out cycle %0d: got %b expected %b", c, bus.valid_out, exp_v);
      end
      if (exp_v) begin
        n_vec++;
        if (bus.product !== ex[c-2]) begin
          n_err++; $display("FAIL b2b product[%0d]: got %h expected %h", c - 2, bus.product, ex[c-2]);
        end
      end
      if (c < 8) begin
        bus.a = va[c];
        bus.b = vb[c];
      end else begin
        bus.valid_in = 1'b0;
      end
    end
  endtask

  task automatic test_stall_random();
    logic [23:0] q [$];
    logic [23:0] cur_a, cur_b, held, expv;
    logic        stalled_prev;
    bit          have;
    int          sent, got, cyc;
    sent = 0; got = 0; cyc = 0; have = 0; stalled_prev = 1'b0;
    held = 24'h0; cur_a = 24'h0; cur_b = 24'h0;
    while ((sent < 200 || q.size() != 0) && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      if (stalled_prev) begin
        n_vec++;
        if (bus.valid_out !== 1'b1 || bus.product !== held) begin
          n_err++; $display("FAIL stall hold cycle %0d: got %b/%h expected 1/%h",
                            cyc, bus.valid_out, bus.product, held);
        end
      end
      if (!have && sent < 200 && $urandom_range(0, 3) != 0) begin
        cur_a = rand_fp();
        cur_b = rand_fp();
        have  = 1;
      end
      bus.valid_in  = have;
      bus.a         = cur_a;
      bus.b         = cur_b;
      bus.ready_out = (sent >= 200) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      n_vec++;
      if (bus.ready_in !== !(bus.valid_out && !bus.ready_out)) begin
        n_err++; $display("FAIL ready_in cycle %0d: got %b with valid_out=%b ready_out=%b",
                          cyc, bus.ready_in, bus.valid_out, bus.ready_out);
      end
      if (bus.valid_out && bus.ready_out) begin
        n_vec++;
        if (q.size() == 0) begin
          n_err++; $display("FAIL stall extra output: got %h expected none", bus.product);
        end else begin
          expv = q.pop_front();
          got++;
          if (bus.product !== expv) begin
            n_err++; $display("FAIL stall product #%0d: got %h expected %h", got, bus.product, expv);
          end
        end
      end
      if (bus.valid_in && bus.ready_in) begin
        q.push_back(ref_mul(cur_a, cur_b));
        sent++;
        have = 0;
      end
      stalled_prev = bus.valid_out && !bus.ready_out;
      held = bus.product;
    end
    bus.valid_in  = 1'b0;
    bus.ready_out = 1'b1;
    n_vec++;
    if (got !== 200) begin
      n_err++; $display("FAIL stall output count: got %0d expected 200 (cycles %0d)", got, cyc);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_vec++;
      if (bus.valid_out !== 1'b0) begin
        n_err++; $display("FAIL stall trailing valid_out: got %b expected 0", bus.valid_out);
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [23:0] prod;
    int          lat;
    bus.ready_out = 1'b1;
    bus.a = 24'h3F8000; bus.b = 24'h3F8000; bus.valid_in = 1'b1;
    @(posedge clk); #1;
    bus.a = 24'h7F0000; bus.b = 24'h7F0000;
    @(posedge clk); #1;
    bus.valid_in  = 1'b0;
    bus.ready_out = 1'b0;
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.valid_out !== 1'b0) begin
      n_err++; $display("FAIL midreset valid_out: got %b expected 0", bus.valid_out);
    end
    n_vec++;
    if (bus.product !== 24'h000000) begin
      n_err++; $display("FAIL midreset product: got %h expected 000000", bus.product);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus.ready_out = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      n_vec++;
      if (bus.valid_out !== 1'b0) begin
        n_err++; $display("FAIL midreset stale valid_out cycle %0d: got %b expected 0", k, bus.valid_out);
      end
    end
    run_one(24'hC08000, 24'h400000, prod, lat);
    n_vec++;
    if (lat !== 2) begin
      n_err++; $display("FAIL midreset recovery latency: got %0d expected 2", lat);
    end
    n_vec++;
    if (prod !== 24'hC18000) begin
      n_err++; $display("FAIL midreset recovery product: got %h expected C18000", prod);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    n_vec = 0;
    n_err = 0;
    bus.a = 24'h0;
    bus.b = 24'h0;
    bus.valid_in  = 1'b0;
    bus.ready_out = 1'b1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall_random();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
